// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop synchroniser, optional debounce, and edge-triggered pending IRQs.
// Define GPIO_IN_DEBOUNCE_EN to build the per-pin debounce counters; otherwise stable follows sync2.
module gpio_in_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   output logic [31:0] read_data,
   input  logic [7:0]  pins_in,
   output logic        irq
);

   localparam logic [31:0] ADDR_PINS = 32'hFFFF_0018;
   localparam logic [31:0] ADDR_EN   = 32'hFFFF_001C;
   localparam logic [31:0] ADDR_PEND = 32'hFFFF_0020;

   logic [7:0] sync1, sync2, stable, stable_nxt;
   logic [7:0] rise_en, fall_en, rise_pend, fall_pend;
   logic [7:0] rise_evt, fall_evt, rise_clr, fall_clr;
   logic       wr_en_sel, wr_pend_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= pins_in;
         sync2 <= sync1;
      end
   end

`ifdef GPIO_IN_DEBOUNCE_EN
   localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic [15:0] cnt     [8];
   logic [15:0] cnt_nxt [8];

   // A pin's stable value only moves after CNT_MAX+1 consecutive mismatches;
   // returning to the stable level at any point restarts the run.
   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < 8; i++) begin
         cnt_nxt[i] = 16'h0000;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_MAX) begin
               stable_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 16'h0001;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) cnt[i] <= 16'h0000;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, write_data[31:16]};
`else
   always_comb stable_nxt = sync2;

   logic unused_ok;
   assign unused_ok = &{1'b0, write_data[31:16], DEBOUNCE_CYCLES[0]};
`endif

   // Edges are judged on the debounced value, in the cycle it changes.
   assign rise_evt = stable_nxt & ~stable;
   assign fall_evt = ~stable_nxt & stable;

   assign wr_en_sel   = write_enable && (address == ADDR_EN);
   assign wr_pend_sel = write_enable && (address == ADDR_PEND);
   assign rise_clr    = wr_pend_sel ? write_data[7:0]  : 8'h00;
   assign fall_clr    = wr_pend_sel ? write_data[15:8] : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         stable    <= 8'h00;
         rise_en   <= 8'h00;
         fall_en   <= 8'h00;
         rise_pend <= 8'h00;
         fall_pend <= 8'h00;
      end else begin
         stable <= stable_nxt;
         if (wr_en_sel) begin
            rise_en <= write_data[7:0];
            fall_en <= write_data[15:8];
         end
         // A new event beats a simultaneous W1C on the same bit.
         rise_pend <= (rise_pend & ~rise_clr) | (rise_evt & rise_en);
         fall_pend <= (fall_pend & ~fall_clr) | (fall_evt & fall_en);
      end
   end

   assign irq = |{fall_pend, rise_pend};

   always_comb begin
      read_data = 32'h0000_0000;
      case (address)
         ADDR_PINS: read_data = {24'h000000, stable};
         ADDR_EN:   read_data = {16'h0000, fall_en, rise_en};
         ADDR_PEND: read_data = {16'h0000, fall_pend, rise_pend};
         default:   read_data = 32'h0000_0000;
      endcase
   end

endmodule
